// File: rtl/fft_pkg.sv
// Shared types and sizes for the FFT output stage: frame geometry, sample layout, capture states.
package fft_pkg;
    localparam int DW      = 16;
    localparam int NPT     = 64;
    localparam int LOG2NPT = 6;
    localparam int RD_LAT  = 1;

    localparam logic [LOG2NPT-2:0] LAST_BEAT = (LOG2NPT-1)'(NPT/2 - 1);
    localparam logic [LOG2NPT-1:0] LAST_IDX  = LOG2NPT'(NPT - 1);

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } sample_t;

    typedef enum logic [1:0] {
        C_IDLE = 2'd0,
        C_RUN  = 2'd1,
        C_DROP = 2'd2
    } cap_state_t;
endpackage

// File: rtl/fft_ostream_bank.sv
// One frame of sample storage: even/odd pair written per beat, combinational read of any index.
// Latency: write visible the cycle after the beat; read is same-cycle. No backpressure.
module fft_ostream_bank
    import fft_pkg::*;
(
    input  logic               CLK,
    input  logic               i_we,
    input  logic [LOG2NPT-2:0] i_waddr,
    input  sample_t            i_wdat_even,
    input  sample_t            i_wdat_odd,
    input  logic [LOG2NPT-1:0] i_raddr,
    output sample_t            o_rdat
);
    sample_t r_mem [NPT];

    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[{i_waddr, 1'b0}] <= i_wdat_even;
            r_mem[{i_waddr, 1'b1}] <= i_wdat_odd;
        end
    end

    assign o_rdat = r_mem[i_raddr];
endmodule

// File: rtl/fft_ostream.sv
// Captures 2-lane FFT result frames into ping-pong banks and replays them 1 sample/cycle in order.
// Latency: first sample valid the cycle after the last beat; drain stalls on OUT_READY, HOLD guards START.
// Optional FFT_OSTREAM_TAG_EN adds OUT_IDX/OUT_FRAME tags.
module fft_ostream
    import fft_pkg::*;
(
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              DONE,
    input  logic              IN_SWAP,
    input  logic [2*DW-1:0]   DIN0,
    input  logic [2*DW-1:0]   DIN1,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [2*DW-1:0]   OUT_DATA,
    output logic              OUT_LAST,
    output logic              HOLD,
    output logic              OVF,
    input  logic              CLR_OVF
`ifdef FFT_OSTREAM_TAG_EN
    ,
    output logic [LOG2NPT-1:0] OUT_IDX,
    output logic [3:0]         OUT_FRAME
`endif
);
    logic [RD_LAT-1:0]  r_done_sr;
    cap_state_t         r_cstate;
    logic [LOG2NPT-2:0] r_beat;
    logic [1:0]         r_full;
    logic               r_wptr;
    logic               r_rptr;
    logic [LOG2NPT-1:0] r_ridx;
    logic               r_hold;
    logic               r_ovf;

    logic               w_cap_en, w_start, w_we, w_cap_done;
    logic               w_drop, w_part, w_rd_hs, w_rd_last;
    logic [LOG2NPT-2:0] w_waddr;
    sample_t            w_wdat_even, w_wdat_odd, w_rdat0, w_rdat1;

    assign w_cap_en    = r_done_sr[RD_LAT-1];
    // Idle with capture enable high is a frame start; this also covers back-to-back DONE bursts.
    assign w_start     = w_cap_en & (r_cstate == C_IDLE);
    assign w_drop      = w_start & r_full[r_wptr];
    assign w_part      = (r_cstate == C_RUN) & ~w_cap_en;
    assign w_we        = (w_start & ~r_full[r_wptr]) | (w_cap_en & (r_cstate == C_RUN));
    assign w_waddr     = (r_cstate == C_RUN) ? r_beat : '0;
    assign w_cap_done  = w_we & (w_waddr == LAST_BEAT);
    assign w_wdat_even = IN_SWAP ? sample_t'(DIN1) : sample_t'(DIN0);
    assign w_wdat_odd  = IN_SWAP ? sample_t'(DIN0) : sample_t'(DIN1);

    assign OUT_VALID   = r_full[r_rptr];
    assign w_rd_hs     = OUT_VALID & OUT_READY;
    assign w_rd_last   = w_rd_hs & (r_ridx == LAST_IDX);
    assign OUT_DATA    = OUT_VALID ? (r_rptr ? w_rdat1 : w_rdat0) : '0;
    assign OUT_LAST    = OUT_VALID & (r_ridx == LAST_IDX);
    assign HOLD        = r_hold;
    assign OVF         = r_ovf;

    fft_ostream_bank u_bank0 (
        .CLK(CLK), .i_we(w_we & ~r_wptr), .i_waddr(w_waddr),
        .i_wdat_even(w_wdat_even), .i_wdat_odd(w_wdat_odd),
        .i_raddr(r_ridx), .o_rdat(w_rdat0)
    );

    fft_ostream_bank u_bank1 (
        .CLK(CLK), .i_we(w_we & r_wptr), .i_waddr(w_waddr),
        .i_wdat_even(w_wdat_even), .i_wdat_odd(w_wdat_odd),
        .i_raddr(r_ridx), .o_rdat(w_rdat1)
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_done_sr <= '0;
            r_cstate  <= C_IDLE;
            r_beat    <= '0;
            r_full    <= '0;
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_ridx    <= '0;
            r_hold    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_done_sr <= (r_done_sr << 1) | RD_LAT'(DONE);

            case (r_cstate)
                C_IDLE: begin
                    if (w_drop) begin
                        r_cstate <= C_DROP;
                    end else if (w_start) begin
                        r_cstate <= C_RUN;
                        r_beat   <= r_beat + 1'b1;
                    end
                end
                C_RUN: begin
                    if (!w_cap_en) begin
                        r_cstate <= C_IDLE;
                        r_beat   <= '0;
                    end else if (r_beat == LAST_BEAT) begin
                        r_cstate <= C_IDLE;
                        r_beat   <= '0;
                        r_wptr   <= ~r_wptr;
                    end else begin
                        r_beat   <= r_beat + 1'b1;
                    end
                end
                C_DROP: begin
                    if (!w_cap_en) r_cstate <= C_IDLE;
                end
                default: r_cstate <= C_IDLE;
            endcase

            // Fill and free never hit the same bank: fill needs it empty, free needs it full.
            for (int b = 0; b < 2; b++) begin
                if (w_cap_done && r_wptr == 1'(b))
                    r_full[b] <= 1'b1;
                else if (w_rd_last && r_rptr == 1'(b))
                    r_full[b] <= 1'b0;
            end

            if (w_rd_hs) begin
                if (r_ridx == LAST_IDX) begin
                    r_ridx <= '0;
                    r_rptr <= ~r_rptr;
                end else begin
                    r_ridx <= r_ridx + 1'b1;
                end
            end

            r_hold <= r_full[r_wptr] | (r_cstate != C_IDLE);

            if (w_drop || w_part)
                r_ovf <= 1'b1;
            else if (CLR_OVF)
                r_ovf <= 1'b0;
        end
    end

`ifdef FFT_OSTREAM_TAG_EN
    logic [3:0] r_frame;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            r_frame <= '0;
        else if (w_rd_last)
            r_frame <= r_frame + 1'b1;
    end

    assign OUT_IDX   = r_ridx;
    assign OUT_FRAME = r_frame;
`endif
endmodule
